// File: rtl/regfile_pkg.sv
// ============================================================================
// Module : regfile_pkg
// Brief  : Shared register-file types and sizes for the write-back path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int REG_DW = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [REG_DW-1:0] data;
    } wb_req_t;

    typedef enum logic {
        WB_SRC_A = 1'b0,
        WB_SRC_L = 1'b1
    } wb_src_e;

endpackage

`default_nettype wire

// File: rtl/regfile_wb_arbiter_if.sv
// ============================================================================
// Module : regfile_wb_arbiter_if
// Brief  : Producer handshakes (ALU port A, load/store port L) into the
//          write-back arbiter. Names are from the arbiter's point of view.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface regfile_wb_arbiter_if
    import regfile_pkg::*;
#(
    parameter int DW = REG_DW,
    parameter int AW = REG_AW
);
    logic          i_a_valid;
    logic          o_a_ready;
    logic [AW-1:0] i_a_rd_addr;
    logic [DW-1:0] i_a_rd_data;
    logic          i_l_valid;
    logic          o_l_ready;
    logic [AW-1:0] i_l_rd_addr;
    logic [DW-1:0] i_l_rd_data;

    modport master (
        output i_a_valid, i_a_rd_addr, i_a_rd_data,
        output i_l_valid, i_l_rd_addr, i_l_rd_data,
        input  o_a_ready, o_l_ready
    );

    modport slave (
        input  i_a_valid, i_a_rd_addr, i_a_rd_data,
        input  i_l_valid, i_l_rd_addr, i_l_rd_data,
        output o_a_ready, o_l_ready
    );
endinterface

`default_nettype wire

// File: rtl/wb_rr_arb2.sv
// ============================================================================
// Module : wb_rr_arb2
// Brief  : Two-requester round-robin arbiter with a registered last-grant
//          pointer. Grants are combinational from the valids and pointer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_rr_arb2
    import regfile_pkg::*;
(
    input  wire  i_clk,
    input  wire  i_rst,
    input  wire  i_valid_a,
    input  wire  i_valid_l,
    output logic o_gnt_a,
    output logic o_gnt_l,
    output logic o_last_grant
);

    wb_src_e r_last;

    // The port that did not win last time takes a contended cycle.
    always_comb begin
        o_gnt_a = i_valid_a && (!i_valid_l || (r_last == WB_SRC_L));
        o_gnt_l = i_valid_l && (!i_valid_a || (r_last == WB_SRC_A));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last <= WB_SRC_L;
        end else if (o_gnt_a) begin
            r_last <= WB_SRC_A;
        end else if (o_gnt_l) begin
            r_last <= WB_SRC_L;
        end
    end

    assign o_last_grant = r_last;

endmodule

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// Module : regfile_wb_arbiter
// Brief  : Round-robin write-back arbiter for the register-file write port,
//          with optional pending-write scoreboard (REGFILE_WB_SCOREBOARD_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DW = REG_DW,
    parameter int AW = REG_AW
) (
    input  wire                  i_clk,
    input  wire                  i_rst,
    regfile_wb_arbiter_if.slave  wb,
    output logic                 o_rd_wren,
    output logic [AW-1:0]        o_rd_addr,
    output logic [DW-1:0]        o_rd_data,
    input  wire                  i_iss_valid,
    input  wire  [AW-1:0]        i_iss_rd_addr,
    output logic [(2**AW)-1:0]   o_busy,
    output logic                 o_last_grant
);

    localparam int c_NREG = 2**AW;

    logic          w_gnt_a;
    logic          w_gnt_l;
    logic          w_xfer;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;

    logic          r_rd_wren;
    logic [AW-1:0] r_rd_addr;
    logic [DW-1:0] r_rd_data;

    wb_rr_arb2 u_arb (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_valid_a    (wb.i_a_valid),
        .i_valid_l    (wb.i_l_valid),
        .o_gnt_a      (w_gnt_a),
        .o_gnt_l      (w_gnt_l),
        .o_last_grant (o_last_grant)
    );

    assign wb.o_a_ready = w_gnt_a;
    assign wb.o_l_ready = w_gnt_l;
    assign w_xfer       = w_gnt_a || w_gnt_l;
    assign w_addr       = w_gnt_l ? wb.i_l_rd_addr : wb.i_a_rd_addr;
    assign w_data       = w_gnt_l ? wb.i_l_rd_data : wb.i_a_rd_data;

    // x0 writes are accepted and consumed but never reach the register file.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_wren <= 1'b0;
            r_rd_addr <= '0;
            r_rd_data <= '0;
        end else begin
            r_rd_wren <= w_xfer && (w_addr != '0);
            if (w_xfer) begin
                r_rd_addr <= w_addr;
                r_rd_data <= w_data;
            end
        end
    end

    assign o_rd_wren = r_rd_wren;
    assign o_rd_addr = r_rd_addr;
    assign o_rd_data = r_rd_data;

`ifdef REGFILE_WB_SCOREBOARD_EN
    logic [c_NREG-1:0] r_busy;
    logic [c_NREG-1:0] w_set;
    logic [c_NREG-1:0] w_clr;

    // A fresh issue to r outranks a retiring write to r in the same cycle.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (i_iss_valid) w_set[i_iss_rd_addr] = 1'b1;
        if (w_xfer)      w_clr[w_addr]        = 1'b1;
        w_set[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr) | w_set;
        end
    end

    assign o_busy = r_busy;
`else
    logic w_unused_iss;
    assign w_unused_iss = ^{i_iss_valid, i_iss_rd_addr};
    assign o_busy       = {c_NREG{1'b0}};
`endif

    a_a_stable: assert property (@(posedge i_clk) disable iff (i_rst)
        (wb.i_a_valid && !wb.o_a_ready) |=>
        (!wb.i_a_valid || ($stable(wb.i_a_rd_addr) && $stable(wb.i_a_rd_data))));

    a_l_stable: assert property (@(posedge i_clk) disable iff (i_rst)
        (wb.i_l_valid && !wb.o_l_ready) |=>
        (!wb.i_l_valid || ($stable(wb.i_l_rd_addr) && $stable(wb.i_l_rd_data))));

endmodule

`default_nettype wire
